// File: rtl/ibpd_debounce.sv
// Synchroniser plus debounce filter for a pulled-down pad input: clean level Q with RISE/FALL strobes.
// Optional rejected-pulse counter on GLITCH_CNT when IBPD_DBNC_GLITCH_CNT_EN is defined.
//
// state     | meaning
// STABLE_LO | Q=0, waiting for S=1
// CHECK_HI  | S went high, counting consecutive high samples
// STABLE_HI | Q=1, waiting for S=0
// CHECK_LO  | S went low, counting consecutive low samples
module ibpd_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 16,
  localparam int CNT_W       = $clog2(DEBOUNCE_CNT + 1)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       I,
  output logic       Q,
  output logic       RISE,
  output logic       FALL,
  output logic       BUSY
`ifdef IBPD_DBNC_GLITCH_CNT_EN
  , output logic [7:0] GLITCH_CNT
`endif
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   s;

  // Plain shift chain: nothing may sit between synchroniser flops.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], I};
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          if (DEBOUNCE_CNT == 1) begin
            state_d = STABLE_HI;
            q_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = CHECK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHECK_HI: begin
        if (s) begin
          if (cnt_inc == CNT_MAX) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            q_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          if (DEBOUNCE_CNT == 1) begin
            state_d = STABLE_LO;
            q_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = CHECK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHECK_LO: begin
        if (!s) begin
          if (cnt_inc == CNT_MAX) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            q_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase
    busy_d = (state_d == CHECK_HI) || (state_d == CHECK_LO);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign Q    = q_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  assign BUSY = busy_q;

`ifdef IBPD_DBNC_GLITCH_CNT_EN
  logic [7:0] gc_q, gc_d;
  logic       glitch;

  // An abort is any qualification that falls back to the level it started from.
  assign glitch = ((state_q == CHECK_HI) && !s) || ((state_q == CHECK_LO) && s);

  always_comb begin
    gc_d = gc_q;
    if (glitch && (gc_q != 8'hFF)) begin
      gc_d = gc_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gc_q <= '0;
    end else begin
      gc_q <= gc_d;
    end
  end

  assign GLITCH_CNT = gc_q;
`endif

endmodule
